cdb_arb: RTL and testbench

Arbiter/scheduler for the common data bus (CDB). Each execution unit (ALU, MDU, LSU) hands its completed result to this block through a valid/ready handshake. The block buffers one result per unit and grants at most one unit per cycle onto a registered CDB broadcast. The broadcast feeds the reservation stations, register file unit and ROB. A flush input discards all in-flight results.

---
 rtl/cdb_arb.sv | 185 ++++++++++++++++++
 tb/tb_cdb_arb.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arb.sv
// cdb_arb: common data bus arbiter.
// Each of the N_REQ execution units (0 = ALU, 1 = MDU, 2 = LSU) has a
// one-entry holding buffer. At most one buffered result per cycle is granted
// onto the registered CDB broadcast.
// Optional feature macro CDB_ARB_RR_EN:
//   defined   -> round-robin arbitration starting at rr_ptr
//   undefined -> fixed priority, lowest index wins (no rr_ptr)
module cdb_arb #(
    parameter int N_REQ  = 3,
    parameter int TAG_W  = 4,
    parameter int ROB_W  = 5,
    parameter int DATA_W = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*TAG_W-1:0]    req_tag,
    input  logic [N_REQ*ROB_W-1:0]    req_rob,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic                      cdb_valid,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [ROB_W-1:0]          cdb_rob,
    output logic [DATA_W-1:0]         cdb_data,
    output logic [N_REQ-1:0]          cdb_src
);

    logic [N_REQ-1:0]  buf_v_q, buf_v_d;
    logic [TAG_W-1:0]  buf_tag_q  [N_REQ];
    logic [TAG_W-1:0]  buf_tag_d  [N_REQ];
    logic [ROB_W-1:0]  buf_rob_q  [N_REQ];
    logic [ROB_W-1:0]  buf_rob_d  [N_REQ];
    logic [DATA_W-1:0] buf_data_q [N_REQ];
    logic [DATA_W-1:0] buf_data_d [N_REQ];

    logic              cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]  cdb_tag_q,   cdb_tag_d;
    logic [ROB_W-1:0]  cdb_rob_q,   cdb_rob_d;
    logic [DATA_W-1:0] cdb_data_q,  cdb_data_d;
    logic [N_REQ-1:0]  cdb_src_q,   cdb_src_d;

    logic [N_REQ-1:0]  grant;
    logic [TAG_W-1:0]  sel_tag;
    logic [ROB_W-1:0]  sel_rob;
    logic [DATA_W-1:0] sel_data;

`ifdef CDB_ARB_RR_EN
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;

    // Round-robin pick: the set buffer closest to rr_ptr (upward, wrapping) wins.
    always_comb begin
        int p;
        int dist;
        int best_dist;
        int gidx;
        grant     = '0;
        rr_ptr_d  = rr_ptr_q;
        p         = int'(rr_ptr_q);
        best_dist = N_REQ;
        gidx      = 0;
        for (int i = 0; i < N_REQ; i++) begin
            dist = (i >= p) ? (i - p) : (i + N_REQ - p);
            if (buf_v_q[i] && (dist < best_dist)) begin
                best_dist = dist;
                gidx      = i;
            end
        end
        if (!flush && (best_dist < N_REQ)) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (i == gidx) grant[i] = 1'b1;
            end
            rr_ptr_d = (gidx == N_REQ - 1) ? '0 : PTR_W'(gidx + 1);
        end
    end

    // Pointer advances past the winner; holds when nothing is granted.
    always_ff @(posedge clk) begin
        if (rst) rr_ptr_q <= '0;
        else     rr_ptr_q <= rr_ptr_d;
    end
`else
    // Fixed priority pick: lowest set index wins.
    always_comb begin
        logic found;
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && buf_v_q[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
        if (flush) grant = '0;
    end
`endif

    // A unit may hand over a result when its buffer is empty or is being drained now.
    assign req_ready = ~{N_REQ{flush}} & (~buf_v_q | grant);

    // Payload of the granted buffer (grant is one-hot or zero).
    always_comb begin
        sel_tag  = '0;
        sel_rob  = '0;
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_tag  = buf_tag_q[i];
                sel_rob  = buf_rob_q[i];
                sel_data = buf_data_q[i];
            end
        end
    end

    // Holding buffers: load on transfer (reload wins over drain), clear on grant or flush.
    always_comb begin
        buf_v_d    = buf_v_q;
        buf_tag_d  = buf_tag_q;
        buf_rob_d  = buf_rob_q;
        buf_data_d = buf_data_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (flush) begin
                buf_v_d[i] = 1'b0;
            end else if (req_valid[i] && req_ready[i]) begin
                buf_v_d[i]    = 1'b1;
                buf_tag_d[i]  = req_tag[i*TAG_W +: TAG_W];
                buf_rob_d[i]  = req_rob[i*ROB_W +: ROB_W];
                buf_data_d[i] = req_data[i*DATA_W +: DATA_W];
            end else if (grant[i]) begin
                buf_v_d[i] = 1'b0;
            end
        end
    end

    // Broadcast register: payload only changes on a grant.
    always_comb begin
        cdb_valid_d = |grant;
        cdb_tag_d   = cdb_tag_q;
        cdb_rob_d   = cdb_rob_q;
        cdb_data_d  = cdb_data_q;
        cdb_src_d   = cdb_src_q;
        if (|grant) begin
            cdb_tag_d  = sel_tag;
            cdb_rob_d  = sel_rob;
            cdb_data_d = sel_data;
            cdb_src_d  = grant;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_v_q     <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                buf_tag_q[i]  <= '0;
                buf_rob_q[i]  <= '0;
                buf_data_q[i] <= '0;
            end
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_rob_q   <= '0;
            cdb_data_q  <= '0;
            cdb_src_q   <= '0;
        end else begin
            buf_v_q     <= buf_v_d;
            buf_tag_q   <= buf_tag_d;
            buf_rob_q   <= buf_rob_d;
            buf_data_q  <= buf_data_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_rob_q   <= cdb_rob_d;
            cdb_data_q  <= cdb_data_d;
            cdb_src_q   <= cdb_src_d;
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_rob   = cdb_rob_q;
    assign cdb_data  = cdb_data_q;
    assign cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arb.sv
// Testbench for cdb_arb: directed scenarios plus random traffic, checked by a
// scoreboard fed from a queue-based reference model of the arbiter.
module tb_cdb_arb;
    localparam int N = 3;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic [2:0]  req_valid, req_ready;
    logic [11:0] req_tag;
    logic [14:0] req_rob;
    logic [95:0] req_data;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [4:0]  cdb_rob;
    logic [31:0] cdb_data;
    logic [2:0]  cdb_src;

    cdb_arb #(.N_REQ(3), .TAG_W(4), .ROB_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_tag(req_tag), .req_rob(req_rob), .req_data(req_data),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_rob(cdb_rob),
        .cdb_data(cdb_data), .cdb_src(cdb_src)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  tag;
        logic [4:0]  rob;
        logic [31:0] data;
        logic [2:0]  src;
        int          cyc;
    } exp_t;
    exp_t sbq[$];

    // Reference model: a set of full/empty slots plus a rotating start index.
    bit          mv[N];
    logic [3:0]  mtag[N];
    logic [4:0]  mrob[N];
    logic [31:0] mdata[N];
    int          mrr;

    // Unit-side presenters (hold payload until accepted).
    bit          pend[N];
    logic [3:0]  ptag[N];
    logic [4:0]  prob[N];
    logic [31:0] pdata[N];
    logic [3:0]  nxt_tag[N];
    logic [4:0]  nxt_rob[N];
    logic [31:0] nxt_data[N];
    bit          rand_pl;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clock cycle: present inputs, check ready, advance the model.
    task automatic cycle(input logic [2:0] want, input bit fl, input bit rs);
        int g;
        logic [2:0] mready;
        exp_t e;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (!pend[i] && want[i]) begin
                pend[i] = 1'b1;
                if (rand_pl) begin
                    ptag[i]  = 4'($urandom);
                    prob[i]  = 5'($urandom);
                    pdata[i] = $urandom;
                end else begin
                    ptag[i]  = nxt_tag[i];
                    prob[i]  = nxt_rob[i];
                    pdata[i] = nxt_data[i];
                    nxt_data[i] = nxt_data[i] + 1;
                end
            end
            req_valid[i]         = pend[i];
            req_tag[i*4 +: 4]    = ptag[i];
            req_rob[i*5 +: 5]    = prob[i];
            req_data[i*32 +: 32] = pdata[i];
        end
        flush = fl;
        rst   = rs;
        #1;
        g = -1;
        if (!fl) begin
`ifdef CDB_ARB_RR_EN
            for (int k = 0; k < N; k++)
                if (g < 0 && mv[(mrr + k) % N]) g = (mrr + k) % N;
`else
            for (int i = 0; i < N; i++)
                if (g < 0 && mv[i]) g = i;
`endif
        end
        for (int i = 0; i < N; i++) mready[i] = !fl && (!mv[i] || g == i);
        chk("req_ready", req_ready, mready);
        if (g >= 0) begin
            if (!rs) begin
                e.tag = mtag[g]; e.rob = mrob[g]; e.data = mdata[g];
                e.src = 3'(1 << g); e.cyc = cyc + 1;
                sbq.push_back(e);
            end
            mv[g] = 1'b0;
            mrr = (g + 1) % N;
        end
        if (fl) for (int i = 0; i < N; i++) mv[i] = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (pend[i] && mready[i]) begin
                mv[i] = 1'b1; mtag[i] = ptag[i]; mrob[i] = prob[i]; mdata[i] = pdata[i];
                pend[i] = 1'b0;
            end
        end
        if (rs) begin
            for (int i = 0; i < N; i++) mv[i] = 1'b0;
            mrr = 0;
        end
    endtask

    // Monitor: every broadcast must match the oldest expected one, on time.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (cdb_valid === 1'b1) begin
                if (sbq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_bcast: got src %0h data %0h, expected no broadcast (cycle %0d)",
                             cdb_src, cdb_data, cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("bcast_cycle", 64'(cyc), 64'(e.cyc));
                    chk("cdb_src", cdb_src, e.src);
                    chk("cdb_tag", cdb_tag, e.tag);
                    chk("cdb_rob", cdb_rob, e.rob);
                    chk("cdb_data", cdb_data, e.data);
                end
            end else begin
                while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
                    checks++; errors++;
                    $display("FAIL missing_bcast: got cdb_valid 0, expected src %0h data %0h (cycle %0d)",
                             sbq[0].src, sbq[0].data, cyc);
                    void'(sbq.pop_front());
                end
            end
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; req_valid = '0;
        req_tag = '0; req_rob = '0; req_data = '0;
        mrr = 0; rand_pl = 1'b0;
        for (int i = 0; i < N; i++) begin
            mv[i] = 1'b0; pend[i] = 1'b0;
            ptag[i] = '0; prob[i] = '0; pdata[i] = '0;
            nxt_tag[i] = 4'(i + 1); nxt_rob[i] = 5'(i + 10); nxt_data[i] = 32'h100 * (i + 1);
        end

        // Reset, then idle
        cycle(3'b000, 1'b0, 1'b1);
        cycle(3'b000, 1'b0, 1'b1);
        cycle(3'b000, 1'b0, 1'b0);
        chk("rst_cdb_valid", cdb_valid, 1'b0);
        chk("rst_cdb_src", cdb_src, 3'b000);

        // Single ALU result
        nxt_tag[0] = 4'h2; nxt_rob[0] = 5'd7; nxt_data[0] = 32'hDEAD_BEEF;
        cycle(3'b001, 1'b0, 1'b0);
        repeat (3) cycle(3'b000, 1'b0, 1'b0);

        // All three at once, twice
        repeat (2) begin
            cycle(3'b111, 1'b0, 1'b0);
            repeat (4) cycle(3'b000, 1'b0, 1'b0);
        end

        // ALU streams 1..4
        nxt_data[0] = 32'd1;
        repeat (4) cycle(3'b001, 1'b0, 1'b0);
        repeat (3) cycle(3'b000, 1'b0, 1'b0);

        // Flush with all buffers full and a broadcast in flight
        cycle(3'b111, 1'b0, 1'b0);
        cycle(3'b111, 1'b0, 1'b0);
        cycle(3'b000, 1'b1, 1'b0);
        cycle(3'b000, 1'b0, 1'b0);
        chk("flush_cdb_valid", cdb_valid, 1'b0);
        repeat (5) cycle(3'b000, 1'b0, 1'b0);

        // ALU and LSU continuously valid
        repeat (8) cycle(3'b101, 1'b0, 1'b0);
        repeat (6) cycle(3'b000, 1'b0, 1'b0);

        // Random traffic with occasional flush and reset
        rand_pl = 1'b1;
        repeat (3000) begin
            cycle(3'($urandom), ($urandom_range(15) == 0), ($urandom_range(299) == 0));
        end

        repeat (20) cycle(3'b000, 1'b0, 1'b0);
        chk("sb_drained", 64'(sbq.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
